motor_sequencer: RTL and testbench

MOTOR_SEQUENCER -- requirements
Module: motor_sequencer

---
 rtl/motor_sequencer.sv | 176 +++++++++++++++++
 tb/tb_motor_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/motor_sequencer.sv
// Two-requester motor sequencer: round-robin grant, limit/abort stop, dead time, fault latch; outputs registered, 1-cycle latency.
// Optional travel timeout is built only when MOTOR_SEQUENCER_TIMEOUT_EN is defined.
module motor_sequencer #(
  parameter int DEAD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] dir,
  input  logic       up_limit,
  input  logic       dn_limit,
  input  logic       fault_clr,
  output logic       motor_up,
  output logic       motor_dn,
  output logic [1:0] grant,
  output logic [1:0] done,
  output logic       fault
);

  typedef enum logic [2:0] {IDLE, RUN_UP, RUN_DN, DEAD, FAULT} state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] done_q, done_d;
  logic       motor_up_q, motor_up_d;
  logic       motor_dn_q, motor_dn_d;
  logic       fault_q, fault_d;
  logic       last_q, last_d;
  logic [7:0] dead_cnt_q, dead_cnt_d;

  logic       pick;
  logic [1:0] pick_oh;
  logic       pick_dir;
  logic       both_lim;
  logic       lim_hit;
  logic       owner_req;

`ifdef MOTOR_SEQUENCER_TIMEOUT_EN
  logic [15:0] travel_cnt_q, travel_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    // Tie goes to the requester not granted last; last_q resets to 1 so requester 0 wins first.
    pick      = (req == 2'b11) ? ~last_q : req[1];
    pick_oh   = pick ? 2'b10 : 2'b01;
    pick_dir  = dir[pick];
    both_lim  = up_limit & dn_limit;
    lim_hit   = (state_q == RUN_UP) ? up_limit : dn_limit;
    owner_req = |(req & grant_q);

    state_d    = state_q;
    grant_d    = grant_q;
    done_d     = 2'b00;
    motor_up_d = motor_up_q;
    motor_dn_d = motor_dn_q;
    fault_d    = fault_q;
    last_d     = last_q;
    dead_cnt_d = dead_cnt_q;
`ifdef MOTOR_SEQUENCER_TIMEOUT_EN
    travel_cnt_d = travel_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (both_lim) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else if (|req) begin
          last_d = pick;
          if ((pick_dir && up_limit) || (!pick_dir && dn_limit)) begin
            // Already at the requested end: complete without moving.
            done_d     = pick_oh;
            state_d    = DEAD;
            dead_cnt_d = 8'd0;
          end else begin
            grant_d    = pick_oh;
            state_d    = pick_dir ? RUN_UP : RUN_DN;
            motor_up_d = pick_dir;
            motor_dn_d = !pick_dir;
`ifdef MOTOR_SEQUENCER_TIMEOUT_EN
            travel_cnt_d = 16'd1;
`endif
          end
        end
      end

      RUN_UP, RUN_DN: begin
        if (both_lim) begin
          state_d    = FAULT;
          fault_d    = 1'b1;
          grant_d    = 2'b00;
          motor_up_d = 1'b0;
          motor_dn_d = 1'b0;
        end else if (lim_hit || !owner_req) begin
          // Completion beats a same-cycle abort.
          done_d     = lim_hit ? grant_q : 2'b00;
          state_d    = DEAD;
          grant_d    = 2'b00;
          motor_up_d = 1'b0;
          motor_dn_d = 1'b0;
          dead_cnt_d = 8'd0;
`ifdef MOTOR_SEQUENCER_TIMEOUT_EN
        end else if (travel_cnt_q == 16'(TIMEOUT_CYCLES)) begin
          state_d    = FAULT;
          fault_d    = 1'b1;
          grant_d    = 2'b00;
          motor_up_d = 1'b0;
          motor_dn_d = 1'b0;
        end else begin
          travel_cnt_d = travel_cnt_q + 16'd1;
`endif
        end
      end

      DEAD: begin
        if (both_lim) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else if (dead_cnt_q == 8'(DEAD_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          dead_cnt_d = dead_cnt_q + 8'd1;
        end
      end

      FAULT: begin
        if (fault_clr) begin
          state_d    = DEAD;
          fault_d    = 1'b0;
          dead_cnt_d = 8'd0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= 2'b00;
      done_q     <= 2'b00;
      motor_up_q <= 1'b0;
      motor_dn_q <= 1'b0;
      fault_q    <= 1'b0;
      last_q     <= 1'b1;
      dead_cnt_q <= 8'd0;
`ifdef MOTOR_SEQUENCER_TIMEOUT_EN
      travel_cnt_q <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      motor_up_q <= motor_up_d;
      motor_dn_q <= motor_dn_d;
      fault_q    <= fault_d;
      last_q     <= last_d;
      dead_cnt_q <= dead_cnt_d;
`ifdef MOTOR_SEQUENCER_TIMEOUT_EN
      travel_cnt_q <= travel_cnt_d;
`endif
    end
  end

  assign motor_up = motor_up_q;
  assign motor_dn = motor_dn_q;
  assign grant    = grant_q;
  assign done     = done_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_motor_sequencer.sv
// Bench for motor_sequencer: done pulses checked against a scoreboard queue, timing/state checked inline per scenario.
module tb_motor_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] dir;
  logic       up_limit;
  logic       dn_limit;
  logic       fault_clr;
  logic       motor_up;
  logic       motor_dn;
  logic [1:0] grant;
  logic [1:0] done;
  logic       fault;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_d;

  always #5 clk = ~clk;

  motor_sequencer #(.DEAD_CYCLES(4), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .dir(dir),
    .up_limit(up_limit), .dn_limit(dn_limit), .fault_clr(fault_clr),
    .motor_up(motor_up), .motor_dn(motor_dn), .grant(grant),
    .done(done), .fault(fault)
  );

  // Monitor: every done pulse must match the next expected entry; motors never both on.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (motor_up && motor_dn) begin
        errors++;
        $display("FAIL motor_excl: up=%b dn=%b, required not both 1", motor_up, motor_dn);
      end
      if (done !== 2'b00) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: got %b, required 00", done);
        end else begin
          exp_d = exp_q.pop_front();
          if (done !== exp_d) begin
            errors++;
            $display("FAIL done_value: got %b, required %b", done, exp_d);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    req = 2'b00; up_limit = 1'b0; dn_limit = 1'b0; fault_clr = 1'b0;
    repeat (7) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 2'b00; dir = 2'b00;
    up_limit = 1'b0; dn_limit = 1'b0; fault_clr = 1'b0;
    #3;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b, required 00", grant); end
    checks++; if (motor_up !== 1'b0 || motor_dn !== 1'b0) begin errors++; $display("FAIL reset_motor: got up=%b dn=%b, required 0 0", motor_up, motor_dn); end
    checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done: got %b, required 00", done); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b, required 0", fault); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    req = 2'b11; dir = 2'b00;
    tick();
    checks++; if (grant !== 2'b01 || motor_dn !== 1'b1) begin errors++; $display("FAIL rr_first: grant=%b dn=%b, required 01 1", grant, motor_dn); end
    repeat (3) tick();
    dn_limit = 1'b1; exp_q.push_back(2'b01);
    tick();
    dn_limit = 1'b0;
    checks++; if (done !== 2'b01 || grant !== 2'b00) begin errors++; $display("FAIL rr_done0: done=%b grant=%b, required 01 00", done, grant); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rr_dead%0d: grant=%b, required 00", i, grant); end
    end
    tick();
    checks++; if (grant !== 2'b10 || motor_dn !== 1'b1) begin errors++; $display("FAIL rr_second: grant=%b dn=%b, required 10 1", grant, motor_dn); end
    repeat (2) tick();
    dn_limit = 1'b1; exp_q.push_back(2'b10);
    tick();
    dn_limit = 1'b0;
    repeat (5) tick();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rr_third: grant=%b, required 01", grant); end
    settle();
  endtask

  task automatic test_single_up();
    req = 2'b01; dir = 2'b01;
    tick();
    checks++; if (grant !== 2'b01 || motor_up !== 1'b1 || motor_dn !== 1'b0) begin errors++; $display("FAIL up_start: grant=%b up=%b dn=%b, required 01 1 0", grant, motor_up, motor_dn); end
    repeat (9) tick();
    checks++; if (motor_up !== 1'b1) begin errors++; $display("FAIL up_hold: up=%b, required 1", motor_up); end
    up_limit = 1'b1; exp_q.push_back(2'b01);
    tick();
    checks++; if (done !== 2'b01 || motor_up !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL up_stop: done=%b up=%b grant=%b, required 01 0 00", done, motor_up, grant); end
    up_limit = 1'b0; dir = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (grant !== 2'b00 || motor_up !== 1'b0 || motor_dn !== 1'b0) begin errors++; $display("FAIL up_dead%0d: grant=%b up=%b dn=%b, required 00 0 0", i, grant, motor_up, motor_dn); end
      if (i == 0) begin
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL up_pulse: done=%b, required 00", done); end
      end
    end
    tick();
    checks++; if (grant !== 2'b01 || motor_dn !== 1'b1) begin errors++; $display("FAIL up_regrant: grant=%b dn=%b, required 01 1", grant, motor_dn); end
    settle();
  endtask

  task automatic test_abort();
    req = 2'b01; dir = 2'b01;
    tick();
    repeat (5) tick();
    req = 2'b00;
    tick();
    checks++; if (motor_up !== 1'b0 || grant !== 2'b00 || done !== 2'b00) begin errors++; $display("FAIL abort_stop: up=%b grant=%b done=%b, required 0 00 00", motor_up, grant, done); end
    req = 2'b10; dir = 2'b10;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL abort_dead%0d: grant=%b, required 00", i, grant); end
    end
    tick();
    checks++; if (grant !== 2'b10 || motor_up !== 1'b1) begin errors++; $display("FAIL abort_regrant: grant=%b up=%b, required 10 1", grant, motor_up); end
    settle();
  endtask

  task automatic test_same_cycle();
    req = 2'b01; dir = 2'b01;
    tick(); tick();
    req = 2'b00; up_limit = 1'b1; exp_q.push_back(2'b01);
    tick();
    checks++; if (done !== 2'b01 || motor_up !== 1'b0) begin errors++; $display("FAIL same_cycle: done=%b up=%b, required 01 0", done, motor_up); end
    settle();
  endtask

  task automatic test_blocked();
    req = 2'b10; dir = 2'b10; up_limit = 1'b1; exp_q.push_back(2'b10);
    tick();
    checks++; if (done !== 2'b10 || motor_up !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL blocked: done=%b up=%b grant=%b, required 10 0 00", done, motor_up, grant); end
    req = 2'b00; up_limit = 1'b0;
    tick();
    checks++; if (done !== 2'b00 || motor_up !== 1'b0) begin errors++; $display("FAIL blocked_after: done=%b up=%b, required 00 0", done, motor_up); end
    settle();
  endtask

  task automatic test_fault();
    req = 2'b01; dir = 2'b00;
    tick();
    checks++; if (motor_dn !== 1'b1) begin errors++; $display("FAIL fault_run: dn=%b, required 1", motor_dn); end
    tick();
    up_limit = 1'b1; dn_limit = 1'b1;
    tick();
    checks++; if (fault !== 1'b1 || motor_dn !== 1'b0 || motor_up !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL fault_enter: fault=%b up=%b dn=%b grant=%b, required 1 0 0 00", fault, motor_up, motor_dn, grant); end
    up_limit = 1'b0; dn_limit = 1'b0;
    repeat (3) tick();
    checks++; if (fault !== 1'b1 || grant !== 2'b00) begin errors++; $display("FAIL fault_hold: fault=%b grant=%b, required 1 00", fault, grant); end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    checks++; if (fault !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL fault_clr: fault=%b grant=%b, required 0 00", fault, grant); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL fault_dead%0d: grant=%b, required 00", i, grant); end
    end
    tick();
    checks++; if (grant !== 2'b01 || motor_dn !== 1'b1) begin errors++; $display("FAIL fault_regrant: grant=%b dn=%b, required 01 1", grant, motor_dn); end
    settle();
  endtask

  task automatic test_timeout();
    req = 2'b01; dir = 2'b01;
    tick();
`ifdef MOTOR_SEQUENCER_TIMEOUT_EN
    repeat (19) tick();
    checks++; if (motor_up !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL timeout_pre: up=%b fault=%b, required 1 0", motor_up, fault); end
    tick();
    checks++; if (motor_up !== 1'b0 || fault !== 1'b1) begin errors++; $display("FAIL timeout_fault: up=%b fault=%b, required 0 1", motor_up, fault); end
    req = 2'b00; fault_clr = 1'b1;
    tick();
`else
    repeat (200) tick();
    checks++; if (motor_up !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL no_timeout: up=%b fault=%b, required 1 0", motor_up, fault); end
`endif
    settle();
  endtask

  task automatic test_reset_mid();
    req = 2'b01; dir = 2'b01;
    tick();
    checks++; if (motor_up !== 1'b1) begin errors++; $display("FAIL rstmid_run: up=%b, required 1", motor_up); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (motor_up !== 1'b0 || grant !== 2'b00 || done !== 2'b00) begin errors++; $display("FAIL rstmid_async: up=%b grant=%b done=%b, required 0 00 00", motor_up, grant, done); end
    req = 2'b00;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if (grant !== 2'b00 || motor_up !== 1'b0) begin errors++; $display("FAIL rstmid_after: grant=%b up=%b, required 00 0", grant, motor_up); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_up();
    test_abort();
    test_same_cycle();
    test_blocked();
    test_fault();
    test_timeout();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL done_missing: %0d expected done pulses never seen, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
